// File: rtl/cpu_control_fsm.sv
// VeriRISC instruction sequencer: fixed 8-phase fetch/decode/execute cycle
// decoding the IR opcode into memory, IR, accumulator and PC strobes.
//
// state      | meaning
// INST_ADDR  | present PC as instruction address
// INST_FETCH | read instruction from memory
// INST_LOAD  | latch instruction into IR
// IDLE       | hold IR load while memory settles
// OP_ADDR    | advance PC; HLT freezes here
// OP_FETCH   | read operand for ALU instructions
// ALU_OP     | execute; SKZ skip, JMP target load
// STORE      | write back accumulator / memory
module cpu_control_fsm (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
    output logic       mem_rd,
    output logic       load_ir,
    output logic       inc_pc,
    output logic       load_ac,
    output logic       load_pc,
    output logic       mem_wr,
    output logic       halt,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    phase_t phase_q, phase_d;
    logic   halted_q, halted_d;
    logic   aluop;

    assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                   (opcode == OP_XOR) || (opcode == OP_LDA);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (phase_q == OP_ADDR && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else begin
                phase_d = phase_t'(phase_q + 3'd1);
            end
        end
    end

    always_comb begin
        mem_rd  = 1'b0;
        load_ir = 1'b0;
        inc_pc  = 1'b0;
        load_ac = 1'b0;
        load_pc = 1'b0;
        mem_wr  = 1'b0;
        halt    = 1'b0;
        if (halted_q) begin
            // Frozen: only the sticky halt flag is visible.
            halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: ;
                INST_FETCH: mem_rd = 1'b1;
                INST_LOAD, IDLE: begin
                    mem_rd  = 1'b1;
                    load_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: mem_rd = aluop;
                ALU_OP: begin
                    mem_rd  = aluop;
                    inc_pc  = (opcode == OP_SKZ) && zero;
                    load_pc = (opcode == OP_JMP);
                end
                STORE: begin
                    mem_rd  = aluop;
                    load_ac = aluop;
                    inc_pc  = (opcode == OP_JMP);
                    load_pc = (opcode == OP_JMP);
                    mem_wr  = (opcode == OP_STO);
                end
                default: ;
            endcase
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: driver queues expected {phase, strobes},
// monitor pops and compares against the DUT at each sample event.
module tb_cpu_control_fsm;

    logic       clk;
    logic       rst_;
    logic [2:0] opcode;
    logic       zero;
    logic       mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt;
    logic [2:0] phase;

    cpu_control_fsm dut (
        .clk     (clk),
        .rst_    (rst_),
        .opcode  (opcode),
        .zero    (zero),
        .mem_rd  (mem_rd),
        .load_ir (load_ir),
        .inc_pc  (inc_pc),
        .load_ac (load_ac),
        .load_pc (load_pc),
        .mem_wr  (mem_wr),
        .halt    (halt),
        .phase   (phase)
    );

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Strobe vector bits: {mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt}
    // Tables list phase 7 leftmost down to phase 0 rightmost.
    localparam logic [7:0][6:0] T_ALU = {7'b1001000, 7'b1000000, 7'b1000000, 7'b0010000,
                                         7'b1100000, 7'b1100000, 7'b1000000, 7'b0000000};
    localparam logic [7:0][6:0] T_SKZ1 = {7'b0000000, 7'b0010000, 7'b0000000, 7'b0010000,
                                          7'b1100000, 7'b1100000, 7'b1000000, 7'b0000000};
    localparam logic [7:0][6:0] T_SKZ0 = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0010000,
                                          7'b1100000, 7'b1100000, 7'b1000000, 7'b0000000};
    localparam logic [7:0][6:0] T_STO = {7'b0000010, 7'b0000000, 7'b0000000, 7'b0010000,
                                         7'b1100000, 7'b1100000, 7'b1000000, 7'b0000000};
    localparam logic [7:0][6:0] T_JMP = {7'b0010100, 7'b0000100, 7'b0000000, 7'b0010000,
                                         7'b1100000, 7'b1100000, 7'b1000000, 7'b0000000};
    localparam logic [7:0][6:0] T_HLT = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0010001,
                                         7'b1100000, 7'b1100000, 7'b1000000, 7'b0000000};
    localparam logic [6:0] V_HALTED = 7'b0000001;
    localparam logic [6:0] V_NONE   = 7'b0000000;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } item_t;

    item_t exp_q[$];
    event  sample_ev;
    int    tests_run = 0;
    int    tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: consumes one expected entry per sample event.
    initial begin
        item_t      it;
        logic [9:0] act;
        forever begin
            @(sample_ev);
            act = {phase, mem_rd, load_ir, inc_pc, load_ac, load_pc, mem_wr, halt};
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL %s: sample with empty scoreboard, actual=%b", "scoreboard", act);
            end else begin
                it = exp_q.pop_front();
                tests_run++;
                if (act !== it.exp) begin
                    tests_failed++;
                    $display("FAIL %s: actual phase=%0d strobes=%b, required phase=%0d strobes=%b",
                             it.name, act[9:7], act[6:0], it.exp[9:7], it.exp[6:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [2:0] ph, input logic [6:0] v);
        item_t it;
        #1;
        it.name = name;
        it.exp  = {ph, v};
        exp_q.push_back(it);
        ->sample_ev;
    endtask

    // Checks n phases starting at phase 0; leaves the bench at the negedge after the last.
    task automatic run_instr(input string name, input logic [7:0][6:0] tbl, input int n);
        logic [2:0] p;
        for (int i = 0; i < n; i++) begin
            p = 3'(i);
            check($sformatf("%s_ph%0d", name, i), p, tbl[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_   = 1'b0;
        opcode = OP_ADD;
        zero   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hold", 3'd0, V_NONE);
        @(negedge clk);
        rst_ = 1'b1;

        run_instr("add", T_ALU, 8);

        opcode = OP_SKZ; zero = 1'b1;
        run_instr("skz_z1", T_SKZ1, 8);
        opcode = OP_SKZ; zero = 1'b0;
        run_instr("skz_z0", T_SKZ0, 8);
        opcode = OP_STO; zero = 1'b1;
        run_instr("sto", T_STO, 8);
        opcode = OP_JMP; zero = 1'b1;
        run_instr("jmp", T_JMP, 8);
        opcode = OP_LDA; zero = 1'b0;
        run_instr("lda", T_ALU, 8);

        // Asynchronous reset in the middle of ALU_OP.
        opcode = OP_LDA;
        run_instr("lda_cut", T_ALU, 6);
        check("lda_cut_ph6", 3'd6, 7'b1000000);
        #1 rst_ = 1'b0;
        check("async_rst_mid", 3'd0, V_NONE);
        @(negedge clk);
        check("async_rst_held", 3'd0, V_NONE);
        rst_ = 1'b1;
        run_instr("add_after_rst", T_ALU, 8);

        opcode = OP_HLT; zero = 1'b0;
        run_instr("hlt", T_HLT, 5);
        for (int i = 0; i < 20; i++) begin
            if (i == 3) opcode = OP_ADD;
            if (i == 8) zero = 1'b1;
            if (i == 12) opcode = OP_JMP;
            check($sformatf("halted_%0d", i), 3'd4, V_HALTED);
            @(negedge clk);
        end
        #1 rst_ = 1'b0;
        check("halt_rst_pulse", 3'd0, V_NONE);
        #1 rst_ = 1'b1;
        opcode = OP_ADD; zero = 1'b0;
        run_instr("add_after_halt", T_ALU, 8);
        check("wrap_ph0", 3'd0, V_NONE);

        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: actual %0d entries left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
